wisc_decode_pipe: RTL and testbench

Parametrised decode stage for the WISC pipeline. It holds the register file and decodes the IF/ID instruction. It also detects load-use, flag and branch-register hazards, and resolves B/BR in decode. The decoded operands and controls are registered into an internal ID/EX pipeline register, which feeds the execute stage directly.

---
 rtl/wisc_decode_pipe_if.sv | 51 +++++
 rtl/wisc_decode_pipe.sv | 164 ++++++++++++++++
 tb/tb_wisc_decode_pipe.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/wisc_decode_pipe_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, hazard/branch outputs and the ID/EX register.
interface wisc_decode_pipe_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 16
);
    logic              ifid_valid;
    logic [15:0]       ifid_instr;
    logic [PC_W-1:0]   ifid_pc_two;
    logic [2:0]        flags;
    logic              ex_stall;
    logic              wb_we;
    logic [3:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic              stall_if;
    logic              br_taken;
    logic              flush_if;
    logic [PC_W-1:0]   br_target;

    logic              idex_valid;
    logic [3:0]        idex_opcode;
    logic [3:0]        idex_rd;
    logic [3:0]        idex_rs;
    logic [3:0]        idex_rt;
    logic [DATA_W-1:0] idex_data1;
    logic [DATA_W-1:0] idex_data2;
    logic [DATA_W-1:0] idex_imm;
    logic              idex_regwrite;
    logic              idex_memread;
    logic              idex_memwrite;
    logic              idex_memtoreg;
    logic              idex_alusrc;
    logic              idex_hlt;
    logic [PC_W-1:0]   idex_pc_two;

    modport master (
        output ifid_valid, ifid_instr, ifid_pc_two, flags, ex_stall, wb_we, wb_rd, wb_data,
        input  stall_if, br_taken, flush_if, br_target,
        input  idex_valid, idex_opcode, idex_rd, idex_rs, idex_rt, idex_data1, idex_data2,
        input  idex_imm, idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg,
        input  idex_alusrc, idex_hlt, idex_pc_two
    );

    modport slave (
        input  ifid_valid, ifid_instr, ifid_pc_two, flags, ex_stall, wb_we, wb_rd, wb_data,
        output stall_if, br_taken, flush_if, br_target,
        output idex_valid, idex_opcode, idex_rd, idex_rs, idex_rt, idex_data1, idex_data2,
        output idex_imm, idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg,
        output idex_alusrc, idex_hlt, idex_pc_two
    );
endinterface

// File: rtl/wisc_decode_pipe.sv
// WISC decode stage: register file, instruction decode, hazard detection,
// branch resolution in decode and the ID/EX pipeline register.
module wisc_decode_pipe #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned PC_W      = 16,
    parameter bit          WB_BYPASS = 1'b1
) (
    input logic               i_clk,
    input logic               i_rst,
    wisc_decode_pipe_if.slave io_bus
);
    localparam logic [3:0] OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6;
    localparam logic [3:0] OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB;
    localparam logic [3:0] OP_B   = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF;

    logic [DATA_W-1:0] r_rf [16];
    logic              r_valid, r_regwrite, r_memread, r_memwrite, r_memtoreg, r_alusrc, r_hlt;
    logic [3:0]        r_opcode, r_rd, r_rs, r_rt;
    logic [DATA_W-1:0] r_data1, r_data2, r_imm;
    logic [PC_W-1:0]   r_pc_two;
    logic              r_halted;

    logic [3:0]        w_op, w_rd, w_rs, w_rt, w_a1, w_a2;
    logic              w_is_alu, w_is_shift, w_is_ll, w_is_lw, w_is_sw, w_is_b, w_is_br, w_is_hlt;
    logic              w_use1, w_use2, w_regwrite, w_alusrc;
    logic [DATA_W-1:0] w_rd1, w_rd2, w_imm;
    logic              w_cond, w_load_use, w_flag_hz, w_br_hz, w_hz, w_br_taken;
    logic [PC_W-1:0]   w_target;

    assign w_op = io_bus.ifid_instr[15:12];
    assign w_rd = io_bus.ifid_instr[11:8];
    assign w_rs = io_bus.ifid_instr[7:4];
    assign w_rt = io_bus.ifid_instr[3:0];

    // Opcode classification, read-port selection and immediate generation
    always_comb begin
        w_is_alu   = (w_op[3] == 1'b0);
        w_is_shift = (w_op == OP_SLL) || (w_op == OP_SRA) || (w_op == OP_ROR);
        w_is_ll    = (w_op == OP_LLB) || (w_op == OP_LHB);
        w_is_lw    = (w_op == OP_LW);
        w_is_sw    = (w_op == OP_SW);
        w_is_b     = (w_op == OP_B);
        w_is_br    = (w_op == OP_BR);
        w_is_hlt   = (w_op == OP_HLT);
        w_a1       = w_is_ll ? w_rd : w_rs;
        w_a2       = w_is_sw ? w_rd : w_rt;
        w_use1     = w_is_alu || w_is_lw || w_is_sw || w_is_ll || w_is_br;
        w_use2     = w_is_alu || w_is_sw;
        w_regwrite = w_is_alu || w_is_lw || w_is_ll || (w_op == OP_PCS);
        w_alusrc   = w_is_lw || w_is_sw || w_is_shift || w_is_ll;
        w_imm      = '0;
        if (w_is_lw || w_is_sw)
            w_imm = {{(DATA_W-5){io_bus.ifid_instr[3]}}, io_bus.ifid_instr[3:0], 1'b0};
        else if (w_is_shift)
            w_imm = {{(DATA_W-4){1'b0}}, io_bus.ifid_instr[3:0]};
        else if (w_is_ll)
            w_imm = {{(DATA_W-8){1'b0}}, io_bus.ifid_instr[7:0]};
    end

    // Register reads; R0 is hard zero and the bypass never forwards a write to R0
    always_comb begin
        w_rd1 = r_rf[w_a1];
        w_rd2 = r_rf[w_a2];
        if (w_a1 == 4'd0)
            w_rd1 = '0;
        else if (WB_BYPASS && io_bus.wb_we && (io_bus.wb_rd == w_a1))
            w_rd1 = io_bus.wb_data;
        if (w_a2 == 4'd0)
            w_rd2 = '0;
        else if (WB_BYPASS && io_bus.wb_we && (io_bus.wb_rd == w_a2))
            w_rd2 = io_bus.wb_data;
    end

    // Hazards against the instruction currently in ID/EX
    always_comb begin
        w_load_use = r_memread && (r_rd != 4'd0) &&
                     ((w_use1 && (r_rd == w_a1)) || (w_use2 && (r_rd == w_a2)));
        w_flag_hz  = (w_is_b || w_is_br) && (r_opcode inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6});
        w_br_hz    = w_is_br && r_regwrite && (r_rd == w_rs) && (w_rs != 4'd0);
        w_hz       = io_bus.ifid_valid && r_valid && (w_load_use || w_flag_hz || w_br_hz);
    end

    // Branch condition on {Z,V,N} and target selection
    always_comb begin
        w_cond = 1'b1;
        case (io_bus.ifid_instr[11:9])
            3'b000:  w_cond = !io_bus.flags[2];
            3'b001:  w_cond = io_bus.flags[2];
            3'b010:  w_cond = !io_bus.flags[2] && !io_bus.flags[0];
            3'b011:  w_cond = io_bus.flags[0];
            3'b100:  w_cond = io_bus.flags[2] || (!io_bus.flags[2] && !io_bus.flags[0]);
            3'b101:  w_cond = io_bus.flags[2] || io_bus.flags[0];
            3'b110:  w_cond = io_bus.flags[1];
            default: w_cond = 1'b1;
        endcase
        w_target = w_is_br ? PC_W'(w_rd1) :
                   io_bus.ifid_pc_two + {{(PC_W-10){io_bus.ifid_instr[8]}}, io_bus.ifid_instr[8:0], 1'b0};
        w_br_taken = io_bus.ifid_valid && (w_is_b || w_is_br) && w_cond && !io_bus.ex_stall &&
                     !w_hz && !r_halted && !i_rst;
    end

    // Register file write port
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 16; i++) r_rf[i] <= '0;
        end else if (io_bus.wb_we && (io_bus.wb_rd != 4'd0)) begin
            r_rf[io_bus.wb_rd] <= io_bus.wb_data;
        end
    end

    // ID/EX register: reset > downstream stall > bubble > load decode
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0; r_opcode <= '0; r_rd <= '0; r_rs <= '0; r_rt <= '0;
            r_data1 <= '0; r_data2 <= '0; r_imm <= '0; r_pc_two <= '0;
            r_regwrite <= 1'b0; r_memread <= 1'b0; r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0; r_alusrc <= 1'b0; r_hlt <= 1'b0; r_halted <= 1'b0;
        end else if (!io_bus.ex_stall) begin
            if (w_hz || r_halted || !io_bus.ifid_valid) begin
                r_valid <= 1'b0; r_opcode <= '0; r_rd <= '0; r_rs <= '0; r_rt <= '0;
                r_data1 <= '0; r_data2 <= '0; r_imm <= '0; r_pc_two <= '0;
                r_regwrite <= 1'b0; r_memread <= 1'b0; r_memwrite <= 1'b0;
                r_memtoreg <= 1'b0; r_alusrc <= 1'b0; r_hlt <= 1'b0;
            end else begin
                r_valid    <= 1'b1;
                r_opcode   <= w_op;
                r_rd       <= w_rd;
                r_rs       <= w_rs;
                r_rt       <= w_rt;
                r_data1    <= w_rd1;
                r_data2    <= w_rd2;
                r_imm      <= w_imm;
                r_pc_two   <= io_bus.ifid_pc_two;
                r_regwrite <= w_regwrite;
                r_memread  <= w_is_lw;
                r_memwrite <= w_is_sw;
                r_memtoreg <= w_is_lw;
                r_alusrc   <= w_alusrc;
                r_hlt      <= w_is_hlt;
                if (w_is_hlt) r_halted <= 1'b1;
            end
        end
    end

    assign io_bus.stall_if      = io_bus.ex_stall || w_hz || r_halted;
    assign io_bus.br_taken      = w_br_taken;
    assign io_bus.flush_if      = w_br_taken;
    assign io_bus.br_target     = w_target;
    assign io_bus.idex_valid    = r_valid;
    assign io_bus.idex_opcode   = r_opcode;
    assign io_bus.idex_rd       = r_rd;
    assign io_bus.idex_rs       = r_rs;
    assign io_bus.idex_rt       = r_rt;
    assign io_bus.idex_data1    = r_data1;
    assign io_bus.idex_data2    = r_data2;
    assign io_bus.idex_imm      = r_imm;
    assign io_bus.idex_regwrite = r_regwrite;
    assign io_bus.idex_memread  = r_memread;
    assign io_bus.idex_memwrite = r_memwrite;
    assign io_bus.idex_memtoreg = r_memtoreg;
    assign io_bus.idex_alusrc   = r_alusrc;
    assign io_bus.idex_hlt      = r_hlt;
    assign io_bus.idex_pc_two   = r_pc_two;
endmodule

// File: tb/tb_wisc_decode_pipe.sv
// Directed bench for wisc_decode_pipe: one DUT with writeback bypass, one without, sharing stimulus.
module tb_wisc_decode_pipe;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    wisc_decode_pipe_if #(.DATA_W(16), .PC_W(16)) u_if1 ();
    wisc_decode_pipe_if #(.DATA_W(16), .PC_W(16)) u_if0 ();

    assign u_if0.ifid_valid  = u_if1.ifid_valid;
    assign u_if0.ifid_instr  = u_if1.ifid_instr;
    assign u_if0.ifid_pc_two = u_if1.ifid_pc_two;
    assign u_if0.flags       = u_if1.flags;
    assign u_if0.ex_stall    = u_if1.ex_stall;
    assign u_if0.wb_we       = u_if1.wb_we;
    assign u_if0.wb_rd       = u_if1.wb_rd;
    assign u_if0.wb_data     = u_if1.wb_data;

    wisc_decode_pipe #(.DATA_W(16), .PC_W(16), .WB_BYPASS(1'b1)) u_dut_byp (
        .i_clk(clk), .i_rst(rst), .io_bus(u_if1.slave));
    wisc_decode_pipe #(.DATA_W(16), .PC_W(16), .WB_BYPASS(1'b0)) u_dut_nobyp (
        .i_clk(clk), .i_rst(rst), .io_bus(u_if0.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        u_if1.ifid_valid = 1'b0; u_if1.ifid_instr = 16'h0000; u_if1.ifid_pc_two = 16'h0000;
        u_if1.flags = 3'b000; u_if1.ex_stall = 1'b0;
        u_if1.wb_we = 1'b0; u_if1.wb_rd = 4'd0; u_if1.wb_data = 16'h0000;
        tick(); tick();

        // Reset state
        chk("rst_valid",  32'(u_if1.idex_valid), 32'd0);
        chk("rst_valid0", 32'(u_if0.idex_valid), 32'd0);
        chk("rst_stall",  32'(u_if1.stall_if), 32'd0);
        chk("rst_br",     32'(u_if1.br_taken), 32'd0);
        chk("rst_flush",  32'(u_if1.flush_if), 32'd0);
        rst = 1'b0;

        // ADD R5,R3,R4 while writing R3=0x1234
        u_if1.ifid_valid = 1'b1; u_if1.ifid_instr = 16'h0534; u_if1.ifid_pc_two = 16'h0002;
        u_if1.wb_we = 1'b1; u_if1.wb_rd = 4'd3; u_if1.wb_data = 16'h1234;
        tick();
        u_if1.wb_we = 1'b0;
        chk("byp_data1",   32'(u_if1.idex_data1), 32'h1234);
        chk("nobyp_data1", 32'(u_if0.idex_data1), 32'h0000);
        chk("add_valid",   32'(u_if1.idex_valid), 32'd1);
        chk("add_regw",    32'(u_if1.idex_regwrite), 32'd1);
        chk("add_rd",      32'(u_if1.idex_rd), 32'd5);

        // LW R2,R1,2 then ADD R4,R2,R2: one load-use bubble
        u_if1.ifid_instr = 16'h8212;
        tick();
        chk("lw_memread", 32'(u_if1.idex_memread), 32'd1);
        chk("lw_memtoreg",32'(u_if1.idex_memtoreg), 32'd1);
        chk("lw_alusrc",  32'(u_if1.idex_alusrc), 32'd1);
        chk("lw_imm",     32'(u_if1.idex_imm), 32'h0004);
        u_if1.ifid_instr = 16'h0422;
        settle();
        chk("lu_stall",   32'(u_if1.stall_if), 32'd1);
        tick();
        chk("lu_bubble",  32'(u_if1.idex_valid), 32'd0);
        chk("lu_bub_regw",32'(u_if1.idex_regwrite), 32'd0);
        chk("lu_release", 32'(u_if1.stall_if), 32'd0);
        tick();
        chk("lu_add_valid", 32'(u_if1.idex_valid), 32'd1);
        chk("lu_add_rd",    32'(u_if1.idex_rd), 32'd4);

        // SUB R6,R3,R3 then B always: flag hazard bubble then taken
        u_if1.ifid_instr = 16'h1633;
        tick();
        chk("sub_op",    32'(u_if1.idex_opcode), 32'h1);
        chk("sub_data1", 32'(u_if0.idex_data1), 32'h1234);
        u_if1.ifid_instr = 16'hCE00; u_if1.ifid_pc_two = 16'h0040;
        settle();
        chk("fl_stall", 32'(u_if1.stall_if), 32'd1);
        chk("fl_br",    32'(u_if1.br_taken), 32'd0);
        tick();
        chk("fl_bubble", 32'(u_if1.idex_valid), 32'd0);
        chk("fl_br2",    32'(u_if1.br_taken), 32'd1);
        chk("fl_flush",  32'(u_if1.flush_if), 32'd1);
        chk("fl_target", 32'(u_if1.br_target), 32'h0040);
        tick();
        chk("b_valid", 32'(u_if1.idex_valid), 32'd1);
        chk("b_regw",  32'(u_if1.idex_regwrite), 32'd0);
        chk("b_op",    32'(u_if1.idex_opcode), 32'hC);

        // B EQ, imm=-4, pc_two=0x20
        u_if1.ifid_instr = 16'hC3FC; u_if1.ifid_pc_two = 16'h0020; u_if1.flags = 3'b100;
        settle();
        chk("beq_taken",  32'(u_if1.br_taken), 32'd1);
        chk("beq_flush",  32'(u_if1.flush_if), 32'd1);
        chk("beq_target", 32'(u_if1.br_target), 32'h0018);
        u_if1.flags = 3'b000;
        settle();
        chk("beq_nt",       32'(u_if1.br_taken), 32'd0);
        chk("beq_nt_flush", 32'(u_if1.flush_if), 32'd0);
        tick();

        // LW R7,R3,-1 then hold ex_stall while writing R0
        u_if1.ifid_instr = 16'h873F;
        tick();
        chk("lw2_imm",   32'(u_if1.idex_imm), 32'hFFFE);
        chk("lw2_data1", 32'(u_if1.idex_data1), 32'h1234);
        chk("lw2_rd",    32'(u_if1.idex_rd), 32'd7);
        u_if1.ex_stall = 1'b1; u_if1.ifid_instr = 16'h0100;
        u_if1.wb_we = 1'b1; u_if1.wb_rd = 4'd0; u_if1.wb_data = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("xs_stall", 32'(u_if1.stall_if), 32'd1);
            tick();
            chk("xs_op",    32'(u_if1.idex_opcode), 32'h8);
            chk("xs_rd",    32'(u_if1.idex_rd), 32'd7);
            chk("xs_imm",   32'(u_if1.idex_imm), 32'hFFFE);
            chk("xs_memrd", 32'(u_if1.idex_memread), 32'd1);
        end
        u_if1.ex_stall = 1'b0;
        settle();
        chk("xs_release", 32'(u_if1.stall_if), 32'd0);
        tick();
        u_if1.wb_we = 1'b0;
        chk("r0_op",    32'(u_if1.idex_opcode), 32'h0);
        chk("r0_rd",    32'(u_if1.idex_rd), 32'd1);
        chk("r0_byp",   32'(u_if1.idex_data1), 32'h0000);
        chk("r0_nobyp", 32'(u_if0.idex_data2), 32'h0000);

        // LLB R9,0x56 then BR R9: register hazard, then target from R9
        u_if1.ifid_instr = 16'hA956;
        tick();
        chk("llb_imm",  32'(u_if1.idex_imm), 32'h0056);
        chk("llb_rd",   32'(u_if1.idex_rd), 32'd9);
        chk("llb_regw", 32'(u_if1.idex_regwrite), 32'd1);
        u_if1.ifid_instr = 16'hDE90;
        settle();
        chk("brr_stall", 32'(u_if1.stall_if), 32'd1);
        chk("brr_br",    32'(u_if1.br_taken), 32'd0);
        u_if1.wb_we = 1'b1; u_if1.wb_rd = 4'd9; u_if1.wb_data = 16'h0100;
        tick();
        u_if1.wb_we = 1'b0;
        chk("brr_bubble", 32'(u_if1.idex_valid), 32'd0);
        chk("brr_taken",  32'(u_if1.br_taken), 32'd1);
        chk("brr_target", 32'(u_if1.br_target), 32'h0100);
        tick();
        chk("br_op",    32'(u_if1.idex_opcode), 32'hD);
        chk("br_data1", 32'(u_if0.idex_data1), 32'h0100);

        // HLT: sticky halt until reset
        u_if1.ifid_instr = 16'hF000;
        tick();
        chk("hlt_flag",  32'(u_if1.idex_hlt), 32'd1);
        chk("hlt_valid", 32'(u_if1.idex_valid), 32'd1);
        u_if1.ifid_instr = 16'h0534;
        settle();
        chk("halt_stall", 32'(u_if1.stall_if), 32'd1);
        tick();
        chk("halt_bub",  32'(u_if1.idex_valid), 32'd0);
        chk("halt_hlt",  32'(u_if1.idex_hlt), 32'd0);
        tick();
        chk("halt_bub2",   32'(u_if1.idex_valid), 32'd0);
        chk("halt_stall2", 32'(u_if1.stall_if), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_valid", 32'(u_if1.idex_valid), 32'd0);
        chk("post_rst_regw",  32'(u_if1.idex_regwrite), 32'd0);
        settle();
        chk("post_rst_stall", 32'(u_if1.stall_if), 32'd0);
        chk("post_rst_br",    32'(u_if1.br_taken), 32'd0);
        tick();
        chk("post_rst_add",   32'(u_if1.idex_valid), 32'd1);
        chk("post_rst_rf",    32'(u_if1.idex_data1), 32'h0000);
        chk("post_rst_rf0",   32'(u_if0.idex_data1), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
